gray_conv_arbiter: RTL and testbench
====================================

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the code width in bits (W >= 2).
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port req0_valid, input, 1 bit: requester 0 offers a binary value.
REQ-005 Port req0_bin, input, W bits: requester 0 binary value.
REQ-006 Port req0_ready, output, 1 bit: requester 0 value accepted this cycle.
REQ-007 Port req1_valid, input, 1 bit: requester 1 offers a binary value.
REQ-008 Port req1_bin, input, W bits: requester 1 binary value.
REQ-009 Port req1_ready, output, 1 bit: requester 1 value accepted this cycle.
REQ-010 Port out_valid, output, 1 bit: out_gray and out_id hold a result.
REQ-011 Port out_gray, output, W bits: Gray code of the accepted binary value.
REQ-012 Port out_id, output, 1 bit: requester that supplied the result (0 or 1).
REQ-013 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 Port done_count, output, 8 bits: number of completed output handshakes, modulo 256.

Function
REQ-015 The conversion SHALL be gray[W-1] = bin[W-1] and gray[i] = bin[i+1] XOR bin[i] for i < W-1, exact for all 2^W inputs.
REQ-016 The output stage SHALL be a two-state machine, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 The stage SHALL be able to load when EMPTY, or when FULL with out_ready=1 in the same cycle.
REQ-018 When the stage can load and exactly one reqN_valid=1, the block SHALL grant that requester.
REQ-019 When the stage can load and both requesters are valid, the block SHALL grant the requester selected by a 1-bit round-robin pointer prio.
REQ-020 reqN_ready SHALL be combinational: 1 only for the granted requester in a cycle where the stage can load, else 0.
REQ-021 At most one of req0_ready and req1_ready SHALL be 1 in any cycle.
REQ-022 On acceptance from requester N, the block SHALL register out_gray = gray(reqN_bin) and out_id = N, and out_valid SHALL be 1 on the next cycle; latency is 1 cycle.
REQ-023 On acceptance from requester N, prio SHALL become the other requester (NOT N).
REQ-024 prio SHALL be unchanged in cycles without an acceptance.
REQ-025 In FULL with out_ready=0, out_gray, out_id and out_valid SHALL remain stable, and both ready outputs SHALL be 0.
REQ-026 In FULL with out_ready=1 and no acceptance, the state SHALL go to EMPTY.
REQ-027 In FULL with out_ready=1 and an acceptance, the state SHALL stay FULL with the new data, giving 1 result per cycle sustained.
REQ-028 done_count SHALL increment by 1 on each cycle with out_valid=1 and out_ready=1, wrapping from 255 to 0.
REQ-029 out_ready while EMPTY SHALL have no effect.
REQ-030 A requester SHALL NOT be granted while its valid=0; reqN_bin is ignored when not accepted.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set: out_valid=0, out_gray=0, out_id=0, prio=0 (requester 0 preferred), done_count=0, state EMPTY.
REQ-032 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-033 A result pending when rst is asserted SHALL be discarded and SHALL NOT be counted, even if out_ready=1 in that cycle.
REQ-034 Normal operation SHALL resume on the first edge with rst=0.

Verification
REQ-035 Reset check: assert rst 2 cycles with both valid=1 -> readies 0 throughout, then out_valid=0, done_count=0; first grant after release goes to requester 0.
REQ-036 Single request: req0_valid=1, req0_bin=4'b1111 with W=4 -> req0_ready=1 that cycle, next cycle out_valid=1, out_gray=4'b1000, out_id=0.
REQ-037 Contention: both valid, req0_bin=4'b0110, req1_bin=4'b1010, out_ready=1 for 4 cycles -> out_id sequence 0,1,0,1 with out_gray 0101,1111,0101,1111, and done_count=4 after the drain cycle.
REQ-038 Backpressure: stage FULL and out_ready=0 for 3 cycles -> outputs stable and both readies 0; on out_ready=1 there is a handshake, a new grant in the same cycle, and done_count+1.
REQ-039 Exhaustive and wrap: stream all 16 binary values 16 times through requester 1 -> every out_gray matches REQ-015, and done_count returns to 0 after 256 handshakes.
REQ-040 Reset mid-transfer: with FULL and out_ready=1, assert rst -> no count increment, next cycle out_valid=0 and done_count=0.

Source files
------------

// File: rtl/gray_conv_arbiter_if.sv
// Bundle between the two binary requesters, the Gray result consumer and the
// arbiter. The block itself uses the slave view. An environment that drives
// the requesters and consumes the result uses the master view.
interface gray_conv_arbiter_if #(
    parameter int W = 4
);
    logic         req0_valid;
    logic [W-1:0] req0_bin;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_bin;
    logic         req1_ready;
    logic         out_valid;
    logic [W-1:0] out_gray;
    logic         out_id;
    logic         out_ready;
    logic [7:0]   done_count;

    modport slave (
        input  req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
        output req0_ready, req1_ready, out_valid, out_gray, out_id, done_count
    );

    modport master (
        output req0_valid, req0_bin, req1_valid, req1_bin, out_ready,
        input  req0_ready, req1_ready, out_valid, out_gray, out_id, done_count
    );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register that
// holds the Gray code of the granted binary value. The block sustains one
// result per cycle. A running count of output handshakes is kept modulo 256.

// Per-requester binary to Gray converter. It is purely combinational.
module gray_conv_lane #(
    parameter int W = 4
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);
    // MSB passes through. Every other bit is XORed with its upper neighbour.
    always_comb gray = bin ^ (bin >> 1);
endmodule

module gray_conv_arbiter #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_conv_arbiter_if.slave    bus
);
    localparam int NUM_REQ = 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                          state_q, state_d;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0][W-1:0]       req_bin;
    logic [NUM_REQ-1:0][W-1:0]       req_gray;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            can_load;
    logic                            accept;
    logic                            gnt_id;
    logic                            prio_q;
    logic [W-1:0]                    out_gray_q;
    logic                            out_id_q;
    logic [7:0]                      cnt_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_bin   = {bus.req1_bin,   bus.req0_bin};

    // Each requester gets its own converter, so the grant only has to mux finished codes.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        gray_conv_lane #(.W(W)) u_lane (
            .bin  (req_bin[g]),
            .gray (req_gray[g])
        );
    end

    // Grant selection, ready generation and next state of the output stage.
    always_comb begin
        state_d   = state_q;
        can_load  = 1'b0;
        gnt_id    = prio_q;
        accept    = 1'b0;
        req_ready = '0;

        // Reset blocks acceptance, so the readies stay low while it is held.
        if (!rst)
            can_load = (state_q == EMPTY) || bus.out_ready;

        unique case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = prio_q;
        endcase

        accept = can_load && (|req_valid);
        if (accept)
            req_ready[gnt_id] = 1'b1;

        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (bus.out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State register. Reset drops any pending result without handing it off.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // Result register and round-robin pointer update on every acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_gray_q <= '0;
            out_id_q   <= 1'b0;
            prio_q     <= 1'b0;
        end else if (accept) begin
            out_gray_q <= req_gray[gnt_id];
            out_id_q   <= gnt_id;
            prio_q     <= ~gnt_id;
        end
    end

    // Count completed handshakes. A handshake in a reset cycle is not counted.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (state_q == FULL && bus.out_ready)
            cnt_q <= cnt_q + 8'd1;
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.out_valid  = (state_q == FULL);
    assign bus.out_gray   = out_gray_q;
    assign bus.out_id     = out_id_q;
    assign bus.done_count = cnt_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter. A cycle-level model predicts the
// readies and the counter. It also pushes expected {id, gray} results into a
// scoreboard queue, and those results are popped as the consumer takes them.
module tb_gray_conv_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    gray_conv_arbiter_if #(.W(W)) bus ();

    gray_conv_arbiter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic        m_full;
    logic        m_prio;
    logic [7:0]  m_cnt;
    logic [W:0]  sb[$];

    // Gray code built bit by bit from its definition.
    function automatic logic [W-1:0] gray_ref(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++)
            g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at rising edge + 1. This task checks at the falling edge,
    // advances the model and then returns at the next rising edge + 1.
    task automatic cycle();
        logic       cl, gid, acc;
        logic [W:0] e;
        #4;
        cl  = !rst && (!m_full || bus.out_ready);
        gid = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
        acc = cl && (bus.req0_valid || bus.req1_valid);
        chk("req0_ready", bus.req0_ready, acc && !gid);
        chk("req1_ready", bus.req1_ready, acc && gid);
        chk("out_valid", bus.out_valid, m_full);
        chk("done_count", bus.done_count, m_cnt);
        if (m_full && sb.size() > 0) begin
            e = sb[0];
            chk("out_gray", bus.out_gray, e[W-1:0]);
            chk("out_id", bus.out_id, e[W]);
        end
        if (rst) begin
            m_full = 1'b0;
            m_prio = 1'b0;
            m_cnt  = '0;
            sb.delete();
        end else begin
            if (m_full && bus.out_ready) begin
                void'(sb.pop_front());
                m_cnt++;
            end
            if (acc) begin
                sb.push_back({gid, gray_ref(gid ? bus.req1_bin : bus.req0_bin)});
                m_prio = !gid;
            end
            m_full = acc || (m_full && !bus.out_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] held_gray;
        logic [7:0]   cnt_before;
        logic [W-1:0] exp_g[4];
        logic         exp_i[4];

        m_full = 1'b0;
        m_prio = 1'b0;
        m_cnt  = '0;
        rst            = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_bin   = 4'h3;
        bus.req1_bin   = 4'hC;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;

        // Reset with both requesters valid. The readies must stay low.
        do_reset();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_gray", bus.out_gray, 4'h0);
        chk("rst_out_id", bus.out_id, 1'b0);
        chk("rst_done_count", bus.done_count, 8'd0);
        cycle();
        chk("first_grant_id", bus.out_id, 1'b0);
        idle_drain();

        // Single request from requester 0.
        bus.req0_valid = 1'b1;
        bus.req0_bin   = 4'b1111;
        bus.out_ready  = 1'b0;
        cycle();
        bus.req0_valid = 1'b0;
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_gray", bus.out_gray, 4'b1000);
        chk("single_id", bus.out_id, 1'b0);
        idle_drain();

        // Contention from a fresh reset. The grants must alternate 0,1,0,1.
        do_reset();
        exp_g = '{4'b0101, 4'b1111, 4'b0101, 4'b1111};
        exp_i = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_bin   = 4'b0110;
        bus.req1_bin   = 4'b1010;
        bus.out_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("cont_gray", bus.out_gray, exp_g[k]);
            chk("cont_id", bus.out_id, exp_i[k]);
        end
        idle_drain();
        chk("cont_count", bus.done_count, 8'd4);

        // Backpressure: hold FULL for 3 cycles, then release.
        bus.req0_valid = 1'b1;
        bus.req0_bin   = 4'h3;
        bus.out_ready  = 1'b0;
        cycle();
        held_gray = 4'h2;
        chk("bp_loaded", bus.out_gray, held_gray);
        bus.req1_valid = 1'b1;
        bus.req0_bin   = 4'h5;
        bus.req1_bin   = 4'h9;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_stable_gray", bus.out_gray, held_gray);
            chk("bp_stable_valid", bus.out_valid, 1'b1);
        end
        cnt_before = bus.done_count;
        bus.out_ready = 1'b1;
        cycle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("bp_new_id", bus.out_id, 1'b1);
        chk("bp_new_gray", bus.out_gray, 4'hD);
        chk("bp_count", bus.done_count, cnt_before + 8'd1);
        idle_drain();

        // Exhaustive sweep through requester 1. The counter wraps back after 256.
        cnt_before = bus.done_count;
        bus.out_ready  = 1'b1;
        bus.req1_valid = 1'b1;
        for (int n = 0; n < 256; n++) begin
            bus.req1_bin = W'(n % 16);
            cycle();
        end
        idle_drain();
        chk("wrap_count", bus.done_count, cnt_before);

        // Reset while FULL with out_ready high. The pending result is not counted.
        bus.req0_valid = 1'b1;
        bus.req0_bin   = 4'hA;
        bus.out_ready  = 1'b0;
        cycle();
        bus.req0_valid = 1'b0;
        bus.out_ready  = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_count", bus.done_count, 8'd0);
        idle_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
